approx_mult_pipe: RTL and testbench

Parametrised, pipelined unsigned approximate multiplier with a valid/ready stream interface. Generalises the fixed 8x8, two-row exchange multipliers to any operand width W and truncation depth L, and adds a per-transaction exact/approximate mode. It sits in the datapath library alongside the combinational approximate multipliers and serves as the drop-in streaming version for accelerator and error-characterisation benches.

---
 rtl/approx_mult_pkg.sv | 40 ++++
 rtl/approx_mult_core.sv | 32 +++
 rtl/approx_mult_pipe.sv | 164 ++++++++++++++++
 tb/tb_approx_mult_pipe.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mult_pkg.sv
// Shared definitions for the streaming approximate multiplier: legal parameter
// ranges, the stat counter type and the compensation-vector helper.
package approx_mult_pkg;

    localparam int unsigned MIN_W  = 2;
    localparam int unsigned MAX_W  = 32;
    localparam int unsigned MIN_L  = 1;
    localparam int unsigned MAX_PW = 2 * MAX_W;
    localparam int unsigned XI_W   = $clog2(MAX_W);
    localparam int unsigned PI_W   = $clog2(MAX_PW);
    localparam int unsigned STAT_W = 32;

    typedef logic [STAT_W-1:0] stat_cnt_t;

    function automatic bit cfg_legal(input int w, input int l);
        return (w >= int'(MIN_W)) && (w <= int'(MAX_W)) &&
               (l >= int'(MIN_L)) && (l <= w - 1);
    endfunction

    // comp[c] = OR of x[i] & y[j] over the dropped rows i < l, restricted to
    // columns c = i + j in w-1 .. w+l-2; every other bit stays zero.
    function automatic logic [MAX_PW-1:0] approx_comp(
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y,
        input int               w,
        input int               l
    );
        logic [MAX_PW-1:0] comp;
        comp = '0;
        for (int i = 0; i < int'(MAX_W); i++) begin
            for (int j = 0; j < int'(MAX_W); j++) begin
                if (i < l && j < w && (i + j) >= (w - 1) && (i + j) <= (w + l - 2)) begin
                    comp[PI_W'(i + j)] = comp[PI_W'(i + j)] | (x[XI_W'(i)] & y[XI_W'(j)]);
                end
            end
        end
        return comp;
    endfunction

endpackage

// File: rtl/approx_mult_core.sv
// Combinational partial products for one beat: the kept high rows, the
// compensation vector that stands in for the dropped rows, and the exact low-row sum.
module approx_mult_core
    import approx_mult_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned L = 2
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] hi_prod,
    output logic [2*W-1:0] comp,
    output logic [2*W-1:0] low_sum
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] y_ext;
    logic [PW-1:0] x_hi_ext;
    logic [PW-1:0] x_lo_ext;

    always_comb begin
        y_ext    = PW'(y);
        x_hi_ext = PW'(x[W-1:L]);
        x_lo_ext = PW'(x[L-1:0]);
        // hi_prod is left unshifted; the << L happens in the final add stage.
        hi_prod  = y_ext * x_hi_ext;
        low_sum  = y_ext * x_lo_ext;
        comp     = PW'(approx_comp(MAX_W'(x), MAX_W'(y), int'(W), int'(L)));
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage valid/ready approximate multiplier with per-beat exact/approx mode.
// Optional error statistics (err_cnt, err_max) are built when APPROX_ERR_STAT_EN is defined.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned L = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic           in_exact,
    output logic           out_valid,
    input  logic           out_ready,
`ifdef APPROX_ERR_STAT_EN
    output logic [2*W-1:0] out_z,
    output stat_cnt_t      err_cnt,
    output logic [2*W-1:0] err_max
`else
    output logic [2*W-1:0] out_z
`endif
);

    localparam int unsigned PW = 2 * W;

    if (!cfg_legal(int'(W), int'(L))) begin : g_bad_cfg
        $error("approx_mult_pipe: W must be 2..32 and L must be 1..W-1");
    end

    logic [PW-1:0] core_hi;
    logic [PW-1:0] core_comp;
    logic [PW-1:0] core_low;

    approx_mult_core #(.W(W), .L(L)) u_core (
        .x       (in_x),
        .y       (in_y),
        .hi_prod (core_hi),
        .comp    (core_comp),
        .low_sum (core_low)
    );

    logic          s1_valid_q, s1_valid_d;
    logic          s1_exact_q, s1_exact_d;
    logic [PW-1:0] s1_hi_q,    s1_hi_d;
    logic [PW-1:0] s1_comp_q,  s1_comp_d;
    logic [PW-1:0] s1_low_q,   s1_low_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] out_z_q,    out_z_d;

    logic          s2_load;
    logic          s1_load;
    logic          accept;
    logic [PW-1:0] hi_sh;
    logic [PW-1:0] approx_z;
    logic [PW-1:0] exact_z;

    always_comb begin
        s2_load  = !out_valid_q || out_ready;
        s1_load  = !s1_valid_q || s2_load;
        accept   = in_valid && s1_load;

        hi_sh    = s1_hi_q << L;
        approx_z = hi_sh + s1_comp_q;
        exact_z  = hi_sh + s1_low_q;

        s1_valid_d = s1_valid_q;
        s1_exact_d = s1_exact_q;
        s1_hi_d    = s1_hi_q;
        s1_comp_d  = s1_comp_q;
        s1_low_d   = s1_low_q;
        if (s1_load) begin
            s1_valid_d = accept;
        end
        if (accept) begin
            s1_exact_d = in_exact;
            s1_hi_d    = core_hi;
            s1_comp_d  = core_comp;
            s1_low_d   = core_low;
        end

        out_valid_d = out_valid_q;
        out_z_d     = out_z_q;
        if (s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_z_d = s1_exact_q ? exact_z : approx_z;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_exact_q  <= 1'b0;
            s1_hi_q     <= '0;
            s1_comp_q   <= '0;
            s1_low_q    <= '0;
            out_valid_q <= 1'b0;
            out_z_q     <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_exact_q  <= s1_exact_d;
            s1_hi_q     <= s1_hi_d;
            s1_comp_q   <= s1_comp_d;
            s1_low_q    <= s1_low_d;
            out_valid_q <= out_valid_d;
            out_z_q     <= out_z_d;
        end
    end

    assign in_ready  = s1_load;
    assign out_valid = out_valid_q;
    assign out_z     = out_z_q;

`ifdef APPROX_ERR_STAT_EN
    logic          s2_exact_q, s2_exact_d;
    logic [PW-1:0] s2_err_q,   s2_err_d;
    stat_cnt_t     err_cnt_q,  err_cnt_d;
    logic [PW-1:0] err_max_q,  err_max_d;

    // The error of the beat sitting in S2 is captured with it, so the stats
    // only move on the emit handshake and stay frozen under back-pressure.
    always_comb begin
        s2_exact_d = s2_exact_q;
        s2_err_d   = s2_err_q;
        if (s2_load && s1_valid_q) begin
            s2_exact_d = s1_exact_q;
            s2_err_d   = exact_z - approx_z;
        end

        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (out_valid_q && out_ready && !s2_exact_q) begin
            if (s2_err_q != '0 && err_cnt_q != '1) begin
                err_cnt_d = err_cnt_q + stat_cnt_t'(1);
            end
            if (s2_err_q > err_max_q) begin
                err_max_d = s2_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_exact_q <= 1'b0;
            s2_err_q   <= '0;
            err_cnt_q  <= '0;
            err_max_q  <= '0;
        end else begin
            s2_exact_q <= s2_exact_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
            err_max_q  <= err_max_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_max = err_max_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Scoreboard bench for approx_mult_pipe: a W=8/L=2 instance for directed,
// back-pressure and reset checks, and a W=6/L=3 instance for an exhaustive sweep.
module tb_approx_mult_pipe;

    logic clk;
    logic rst_n;

    logic        in_valid8, in_ready8, in_exact8, out_valid8, out_ready8;
    logic [7:0]  in_x8, in_y8;
    logic [15:0] out_z8;
    logic        in_valid6, in_ready6, in_exact6, out_valid6, out_ready6;
    logic [5:0]  in_x6, in_y6;
    logic [11:0] out_z6;
`ifdef APPROX_ERR_STAT_EN
    logic [31:0] err_cnt8, err_cnt6;
    logic [15:0] err_max8;
    logic [11:0] err_max6;
`endif

    int tests = 0;
    int fails = 0;
    logic [15:0] q8[$];
    logic [11:0] q6[$];

    approx_mult_pipe #(.W(8), .L(2)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_x(in_x8), .in_y(in_y8), .in_exact(in_exact8),
        .out_valid(out_valid8), .out_ready(out_ready8),
`ifdef APPROX_ERR_STAT_EN
        .out_z(out_z8), .err_cnt(err_cnt8), .err_max(err_max8)
`else
        .out_z(out_z8)
`endif
    );

    approx_mult_pipe #(.W(6), .L(3)) dut6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid6), .in_ready(in_ready6),
        .in_x(in_x6), .in_y(in_y6), .in_exact(in_exact6),
        .out_valid(out_valid6), .out_ready(out_ready6),
`ifdef APPROX_ERR_STAT_EN
        .out_z(out_z6), .err_cnt(err_cnt6), .err_max(err_max6)
`else
        .out_z(out_z6)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent evaluation of the approximate product straight from its definition.
    function automatic longint model_approx(input longint x, input longint y, input int w, input int l);
        longint hi;
        longint comp;
        hi   = (y * (x >> l)) << l;
        comp = 0;
        for (int c = w - 1; c <= w + l - 2; c++) begin
            bit b;
            b = 1'b0;
            for (int i = 0; i < l; i++) begin
                if (c - i >= 0 && c - i <= w - 1) begin
                    b = b | ((((x >> i) & 1) != 0) && (((y >> (c - i)) & 1) != 0));
                end
            end
            if (b) comp = comp | (longint'(1) << c);
        end
        return hi + comp;
    endfunction

    function automatic logic [15:0] exp8(input logic [7:0] x, input logic [7:0] y, input logic e);
        if (e) return 16'(longint'(x) * longint'(y));
        return 16'(model_approx(longint'(x), longint'(y), 8, 2));
    endfunction

    task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic e, input logic [15:0] z);
        logic got;
        in_x8 = x; in_y8 = y; in_exact8 = e; in_valid8 = 1'b1;
        q8.push_back(z);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = in_ready8;
        end
        chk("send8_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic send6(input logic [5:0] x, input logic [5:0] y, input logic [11:0] z);
        logic got;
        in_x6 = x; in_y6 = y; in_exact6 = 1'b0; in_valid6 = 1'b1;
        q6.push_back(z);
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(negedge clk);
            got = in_ready6;
        end
        if (!got) chk("send6_accept", 64'(got), 64'd1);
        @(posedge clk); #1;
        in_valid6 = 1'b0;
    endtask

    task automatic drain8(input string tag);
        for (int k = 0; k < 100 && q8.size() != 0; k++) @(posedge clk);
        #1;
        chk(tag, 64'(q8.size()), 64'd0);
    endtask

    task automatic drain6(input string tag);
        for (int k = 0; k < 100 && q6.size() != 0; k++) @(posedge clk);
        #1;
        chk(tag, 64'(q6.size()), 64'd0);
    endtask

    // Output monitor: scoreboard pops, hold stability and in_ready occupancy model.
    initial begin : mon
        int          fl8;
        logic        hold8;
        logic [15:0] held8;
        logic [15:0] e8;
        logic [11:0] e6;
        fl8 = 0; hold8 = 1'b0; held8 = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                fl8 = 0;
                hold8 = 1'b0;
            end else begin
                chk("in_ready8", 64'(in_ready8), 64'(!(fl8 == 2 && !out_ready8)));
                if (hold8) begin
                    chk("hold_valid8", 64'(out_valid8), 64'd1);
                    chk("hold_z8", 64'(out_z8), 64'(held8));
                end
                if (out_valid8 === 1'b1 && out_ready8) begin
                    chk("unexpected_out8", 64'(q8.size() != 0), 64'd1);
                    if (q8.size() != 0) begin
                        e8 = q8.pop_front();
                        chk("out_z8", 64'(out_z8), 64'(e8));
                    end
                end
                if (out_valid6 === 1'b1 && out_ready6) begin
                    if (q6.size() == 0) begin
                        chk("unexpected_out6", 64'd0, 64'd1);
                    end else begin
                        e6 = q6.pop_front();
                        chk("out_z6", 64'(out_z6), 64'(e6));
                    end
                end
                hold8 = out_valid8 && !out_ready8;
                held8 = out_z8;
                fl8 = fl8 + int'(in_valid8 && in_ready8) - int'(out_valid8 && out_ready8);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          lat;
        bit          done;
        longint      m, ex, err, max_err, n_err;
        logic [7:0]  rx, ry;
        logic        re;
        logic [3:0]  pat;

        rst_n = 1'b0;
        in_valid8 = 1'b0; in_x8 = '0; in_y8 = '0; in_exact8 = 1'b0; out_ready8 = 1'b1;
        in_valid6 = 1'b0; in_x6 = '0; in_y6 = '0; in_exact6 = 1'b0; out_ready6 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid8", 64'(out_valid8), 64'd0);
        chk("rst_out_z8", 64'(out_z8), 64'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready8", 64'(in_ready8), 64'd1);
        chk("rel_out_valid6", 64'(out_valid6), 64'd0);
`ifdef APPROX_ERR_STAT_EN
        chk("rel_err_cnt8", 64'(err_cnt8), 64'd0);
        chk("rel_err_max8", 64'(err_max8), 64'd0);
`endif

        // Latency: one exact beat, 7*9.
        @(posedge clk); #1;
        in_x8 = 8'd7; in_y8 = 8'd9; in_exact8 = 1'b1; in_valid8 = 1'b1;
        q8.push_back(16'd63);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (out_valid8) break;
        end
        chk("latency", 64'(lat), 64'd2);
        @(posedge clk); #1;

        // Directed values with known results.
        send8(8'd255, 8'd255, 1'b0, 16'd64644);
        send8(8'd3,   8'd200, 1'b0, 16'd384);
        send8(8'd4,   8'd5,   1'b0, 16'd20);
        send8(8'd255, 8'd255, 1'b1, 16'd65025);
        send8(8'd0,   8'd255, 1'b0, 16'd0);
        drain8("drain_directed");
`ifdef APPROX_ERR_STAT_EN
        chk("dir_err_cnt8", 64'(err_cnt8), 64'd2);
        chk("dir_err_max8", 64'(err_max8), 64'd381);
`endif

        // Back-to-back beats under a 1,0,0,1 out_ready pattern.
        @(posedge clk); #1;
        done = 1'b0;
        pat = 4'b1001;
        fork
            begin
                for (int b = 0; b < 16; b++) begin
                    rx = 8'($urandom_range(0, 255));
                    ry = 8'($urandom_range(0, 255));
                    re = (b % 5 == 3);
                    send8(rx, ry, re, exp8(rx, ry, re));
                end
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 400 && !done; k++) begin
                    out_ready8 = pat[k % 4];
                    @(posedge clk); #1;
                end
            end
        join
        out_ready8 = 1'b1;
        drain8("drain_backpressure");

        // Reset with two beats in flight.
        @(posedge clk); #1;
        out_ready8 = 1'b0;
        send8(8'd200, 8'd201, 1'b0, exp8(8'd200, 8'd201, 1'b0));
        send8(8'd17,  8'd99,  1'b1, exp8(8'd17, 8'd99, 1'b1));
        chk("full_in_ready8", 64'(in_ready8), 64'd0);
        chk("full_out_valid8", 64'(out_valid8), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid8", 64'(out_valid8), 64'd0);
        chk("midrst_out_z8", 64'(out_z8), 64'd0);
        q8.delete();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready8 = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_out_valid8", 64'(out_valid8), 64'd0);
`ifdef APPROX_ERR_STAT_EN
        chk("post_rst_err_cnt8", 64'(err_cnt8), 64'd0);
`endif

        // Exhaustive W=6, L=3 approximate sweep.
        max_err = 0;
        n_err = 0;
        @(posedge clk); #1;
        for (int x = 0; x < 64; x++) begin
            for (int y = 0; y < 64; y++) begin
                m   = model_approx(longint'(x), longint'(y), 6, 3);
                ex  = longint'(x) * longint'(y);
                err = ex - m;
                if (err != 0) n_err++;
                if (err > max_err) max_err = err;
                send6(6'(x), 6'(y), 12'(m));
            end
        end
        drain6("drain_sweep");
        chk("sweep_model_max_nonneg", 64'(max_err > 0), 64'd1);
`ifdef APPROX_ERR_STAT_EN
        chk("sweep_err_max6", 64'(err_max6), 64'(max_err));
        chk("sweep_err_cnt6", 64'(err_cnt6), 64'(n_err));
`endif

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
